// File: rtl/noc_mesh_pkg.sv
// noc_mesh_pkg: shared mesh constants, port enum, flit layout and XY route function
package noc_mesh_pkg;
  localparam int MESH_DIM = 4;
  localparam int DATA_W = 8;
  localparam int FLIT_W = DATA_W + 8;
  typedef enum logic [2:0] {P_L, P_N, P_S, P_E, P_W} port_e;
  typedef struct packed {
    logic [1:0] dst_r;
    logic [1:0] dst_c;
    logic [1:0] src_r;
    logic [1:0] src_c;
    logic [DATA_W-1:0] payload;
  } flit_t;
  function automatic port_e route(flit_t f, logic [1:0] r, logic [1:0] c);
    return f.dst_c > c ? P_E : f.dst_c < c ? P_W : f.dst_r > r ? P_S : f.dst_r < r ? P_N : P_L;
  endfunction
endpackage

// File: rtl/noc_router.sv
// noc_router: 5-port XY router with 2-deep input FIFOs, round-robin output arbiters and a registered eject port
module noc_router
  import noc_mesh_pkg::*;
#(
  parameter int R = 0,
  parameter int C = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  i_valid,
  input  flit_t [4:0] i_data,
  output logic [4:0]  o_ready,
  output logic [4:0]  o_valid,
  output flit_t [4:0] o_data,
  input  logic [4:0]  i_ready
);
  flit_t r_mem [5][2];
  logic [1:0] r_cnt [5];
  logic [4:0] r_rd;
  logic [2:0] r_ptr [5];
  logic r_ov;
  flit_t r_od;
  flit_t w_head [5];
  port_e w_dir [5];
  logic [2:0] w_gi [5];
  logic [4:0] w_hv, w_gv, w_tx, w_pop, w_push;
  always_comb begin
    int j;
    j = 0;
    for (int i = 0; i < 5; i++) begin
      w_head[i] = r_mem[i][r_rd[i]];
      w_hv[i] = r_cnt[i] != 2'd0;
      w_dir[i] = route(w_head[i], 2'(R), 2'(C));
      o_ready[i] = r_cnt[i] != 2'd2;
      w_push[i] = i_valid[i] && o_ready[i];
    end
    // Search starts at the pointer and wraps, so the port after the last winner goes first
    for (int o = 0; o < 5; o++) begin
      w_gv[o] = 1'b0;
      w_gi[o] = 3'd0;
      for (int k = 0; k < 5; k++) begin
        j = (int'(r_ptr[o]) + k) % 5;
        if (!w_gv[o] && w_hv[j] && w_dir[j] == port_e'(o)) begin
          w_gv[o] = 1'b1;
          w_gi[o] = 3'(j);
        end
      end
      w_tx[o] = w_gv[o] && (o == 0 ? (!r_ov || i_ready[o]) : i_ready[o]);
      o_valid[o] = o == 0 ? r_ov : w_gv[o];
      o_data[o] = o == 0 ? r_od : w_head[w_gi[o]];
    end
    for (int i = 0; i < 5; i++)
      w_pop[i] = w_hv[i] && w_gi[w_dir[i]] == 3'(i) && w_tx[w_dir[i]];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rd <= '0;
      r_ov <= 1'b0;
      r_od <= '0;
      for (int i = 0; i < 5; i++) begin
        r_cnt[i] <= '0;
        r_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        r_cnt[i] <= r_cnt[i] + 2'(w_push[i]) - 2'(w_pop[i]);
        r_rd[i] <= r_rd[i] ^ w_pop[i];
        if (w_tx[i]) r_ptr[i] <= w_gi[i] == 3'd4 ? 3'd0 : w_gi[i] + 3'd1;
      end
      if (!r_ov || i_ready[P_L]) begin
        r_ov <= w_gv[P_L];
        if (w_gv[P_L]) r_od <= w_head[w_gi[P_L]];
      end
    end
  always_ff @(posedge clk)
    for (int i = 0; i < 5; i++)
      if (w_push[i]) r_mem[i][r_rd[i] ^ r_cnt[i][0]] <= i_data[i];
endmodule

// File: rtl/noc_mesh.sv
// noc_mesh: 4x4 XY-routed mesh of noc_router instances with valid/ready links.
// Define NOC_STATS_EN to add the saturating stat_delivered counter.
module noc_mesh #(
  parameter int DATA_W = 8,
  parameter int FLIT_W = DATA_W + 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          in_valid,
  input  logic [16*FLIT_W-1:0] in_data,
  output logic [15:0]          in_ready,
  output logic [15:0]          out_valid,
  output logic [16*FLIT_W-1:0] out_data,
  input  logic [15:0]          out_ready
`ifdef NOC_STATS_EN
  ,
  output logic [15:0]          stat_delivered
`endif
);
  import noc_mesh_pkg::*;
  logic [4:0] w_ov [16];
  logic [4:0] w_or [16];
  flit_t [4:0] w_od [16];
  for (genvar n = 0; n < 16; n++) begin : g_node
    localparam int R = n / MESH_DIM;
    localparam int C = n % MESH_DIM;
    // Edge neighbours point at self; the constant guards below keep them unused
    localparam int NN = R > 0 ? n - 4 : n;
    localparam int NS = R < 3 ? n + 4 : n;
    localparam int NE = C < 3 ? n + 1 : n;
    localparam int NW = C > 0 ? n - 1 : n;
    logic [4:0] w_iv, w_ir;
    flit_t [4:0] w_id;
    assign w_iv = {C > 0 && w_ov[NW][P_E], C < 3 && w_ov[NE][P_W], R < 3 && w_ov[NS][P_N],
                   R > 0 && w_ov[NN][P_S], in_valid[n]};
    assign w_ir = {C > 0 && w_or[NW][P_E], C < 3 && w_or[NE][P_W], R < 3 && w_or[NS][P_N],
                   R > 0 && w_or[NN][P_S], out_ready[n]};
    assign w_id = {w_od[NW][P_E], w_od[NE][P_W], w_od[NS][P_N], w_od[NN][P_S],
                   flit_t'(in_data[n*FLIT_W +: FLIT_W])};
    noc_router #(.R(R), .C(C)) u_router (
      .clk(clk), .rst_n(rst_n),
      .i_valid(w_iv), .i_data(w_id), .o_ready(w_or[n]),
      .o_valid(w_ov[n]), .o_data(w_od[n]), .i_ready(w_ir)
    );
    assign in_ready[n] = w_or[n][P_L];
    assign out_valid[n] = w_ov[n][P_L];
    assign out_data[n*FLIT_W +: FLIT_W] = w_od[n][P_L];
  end
`ifdef NOC_STATS_EN
  logic [15:0] r_stat;
  logic [16:0] w_sum;
  assign w_sum = {1'b0, r_stat} + 17'($countones(out_valid & out_ready));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_stat <= '0;
    else r_stat <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
  assign stat_delivered = r_stat;
`endif
endmodule

// File: tb/tb_noc_mesh.sv
// tb_noc_mesh: queue-driven stimulus with a per source/destination scoreboard for noc_mesh
module tb_noc_mesh;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [15:0] in_valid = '0;
  logic [255:0] in_data = '0;
  logic [15:0] in_ready;
  logic [15:0] out_valid;
  logic [255:0] out_data;
  logic [15:0] out_ready = '1;
`ifdef NOC_STATS_EN
  logic [15:0] stat_delivered;
`endif
  int checks = 0;
  int errors = 0;
  logic [15:0] src_q [16][$];
  logic [15:0] exp_q [256][$];
  int del_cnt [16];
  bit rand_rdy = 1'b0;

  noc_mesh dut (
`ifdef NOC_STATS_EN
    .stat_delivered(stat_delivered),
`endif
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mk(int s, int d, int p);
    logic [3:0] sv, dv;
    sv = 4'(s);
    dv = 4'(d);
    return {dv, sv, 8'(p)};
  endfunction

  function automatic int pending();
    int p;
    p = 0;
    for (int s = 0; s < 16; s++) p += src_q[s].size();
    for (int k = 0; k < 256; k++) p += exp_q[k].size();
    return p;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: a handshake seen at the negedge completes at the following posedge
  always @(negedge clk) begin
    logic [15:0] f, e;
    int k;
    if (rst_n)
      for (int d = 0; d < 16; d++)
        if (out_valid[d] && out_ready[d]) begin
          f = out_data[d*16 +: 16];
          k = int'(f[11:8]) * 16 + d;
          checks++;
          del_cnt[d]++;
          if (exp_q[k].size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected node=%0d actual=%h required=none", d, f);
          end else begin
            e = exp_q[k].pop_front();
            if (f !== e) begin
              errors++;
              $display("FAIL sb_data node=%0d actual=%h required=%h", d, f, e);
            end
          end
        end
  end

  task automatic step();
    logic [15:0] acc, f;
    @(negedge clk);
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int s = 0; s < 16; s++) begin
      if (acc[s]) begin
        f = src_q[s].pop_front();
        exp_q[s*16 + int'(f[15:12])].push_back(f);
      end
      in_valid[s] = src_q[s].size() != 0;
      if (in_valid[s]) in_data[s*16 +: 16] = src_q[s][0];
      else in_data[s*16 +: 16] = 16'h0;
    end
    if (rand_rdy) out_ready = 16'($urandom) | 16'($urandom);
  endtask

  task automatic drain(int bound, string nm);
    int c;
    c = 0;
    while (pending() != 0 && c < bound) begin
      step();
      c++;
    end
    chk({nm, "_pending"}, pending(), 0);
  endtask

  task automatic lat_test(int s, int d, int p, int lat, string nm);
    logic [15:0] f, others;
    int i;
    f = mk(s, d, p);
    others = '0;
    i = 0;
    src_q[s].push_back(f);
    step();
    step();
    chk({nm, "_accepted"}, src_q[s].size(), 0);
    while (!out_valid[d] && i < 20) begin
      step();
      others |= out_valid & ~(16'd1 << d);
      i++;
    end
    chk({nm, "_latency"}, i, lat);
    chk({nm, "_data"}, out_data[d*16 +: 16], f);
    chk({nm, "_others"}, others, 0);
    drain(20, nm);
  endtask

  task automatic do_reset(string nm);
    rst_n = 1'b0;
    #1;
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out_data0"}, out_data[31:0], 0);
    chk({nm, "_in_ready"}, in_ready, 16'hFFFF);
`ifdef NOC_STATS_EN
    chk({nm, "_stat"}, stat_delivered, 0);
`endif
    for (int s = 0; s < 16; s++) src_q[s].delete();
    for (int k = 0; k < 256; k++) exp_q[k].delete();
    in_valid = '0;
    in_data = '0;
    rand_rdy = 1'b0;
    out_ready = '1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b, unstable;
    bit dropped, seen;
    logic [15:0] held;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_in_ready", in_ready, 16'hFFFF);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data[255:224], 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    lat_test(0, 0, 'h5A, 1, "self");
    lat_test(0, 15, 'hC3, 7, "corner");
    b = del_cnt[6];
    for (int n = 0; n < 16; n++) src_q[n].push_back(mk(n, 6, n));
    for (int n = 0; n < 16; n++) src_q[n].push_back(mk(n, 6, n + 16));
    drain(500, "all_to_6");
    chk("all_to_6_count", del_cnt[6] - b, 32);
    out_ready[5] = 1'b0;
    b = del_cnt[5];
    for (int i = 0; i < 10; i++) src_q[0].push_back(mk(0, 5, 'h30 + i));
    dropped = 0;
    seen = 0;
    unstable = 0;
    held = '0;
    repeat (30) begin
      step();
      if (!in_ready[0]) dropped = 1;
      if (out_valid[5]) begin
        if (!seen) begin
          seen = 1;
          held = out_data[80 +: 16];
        end else if (out_data[80 +: 16] != held) unstable++;
      end
    end
    chk("stall_in_ready_drop", 32'(dropped), 1);
    chk("stall_valid", 32'(seen), 1);
    chk("stall_head", held, mk(0, 5, 'h30));
    chk("stall_stable", unstable, 0);
    chk("stall_held_back", del_cnt[5] - b, 0);
    out_ready = '1;
    drain(200, "stall_release");
    chk("stall_count", del_cnt[5] - b, 10);
    do_reset("pre_rand_rst");
    b = 0;
    for (int d = 0; d < 16; d++) b += del_cnt[d];
    for (int i = 0; i < 10000; i++) begin
      int s, d;
      s = int'($urandom_range(15));
      d = int'($urandom_range(15));
      src_q[s].push_back(mk(s, d, i));
    end
    rand_rdy = 1'b1;
    drain(40000, "random");
    rand_rdy = 1'b0;
    out_ready = '1;
    for (int d = 0; d < 16; d++) b -= del_cnt[d];
    chk("random_count", -b, 10000);
`ifdef NOC_STATS_EN
    chk("random_stat", stat_delivered, 10000);
`endif
    for (int i = 0; i < 2000; i++) begin
      int s, d;
      s = int'($urandom_range(15));
      d = int'($urandom_range(15));
      src_q[s].push_back(mk(s, d, i));
    end
    rand_rdy = 1'b1;
    repeat (60) step();
    do_reset("mid_rst");
    lat_test(15, 0, 'h77, 7, "post_rst_corner");
    lat_test(9, 9, 'h99, 1, "post_rst_self");
`ifdef NOC_STATS_EN
    chk("post_rst_stat", stat_delivered, 2);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_mesh.md
# noc_mesh

4x4 mesh network-on-chip connecting 16 endpoint nodes, addressed (r,c) with r,c in 0..3 and flat index n = 4*r + c. Each node has one injection port into the network and one ejection port out of it. The testbench drives all 16 injection ports and consumes all 16 ejection ports. Delivery uses deterministic XY (column-first) routing over registered per-hop links, with valid/ready backpressure end to end.

## Interface
- Parameters:
- DATA_W, 8: payload bits per flit.
- FLIT_W, DATA_W+8: flit width. Bits [FLIT_W-1 -: 2] dst_r, then dst_c, src_r, src_c (2 bits each), then payload [DATA_W-1:0].
- Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  16  node n offers a flit.
- in_data  in  16*FLIT_W  flit for node n at bits [n*FLIT_W +: FLIT_W].
- in_ready  out  16  network accepts node n's flit this cycle.
- out_valid  out  16  flit available for node n.
- out_data  out  16*FLIT_W  delivered flit, same packing as in_data.
- out_ready  in  16  node n consumes its flit this cycle.
- stat_delivered  out  16  total flits ejected, saturating. Present only with NOC_STATS_EN.

## Operation
- One router per node. Each router has 5 input ports (L, N, S, E, W), and each input port has a 2-entry FIFO.
- Directions: N is r-1, S is r+1, W is c-1, E is c+1. Mesh-edge ports are tied off: never valid, never ready.
- Routing, decided from the head flit's dst:
  - dst_c > c: E. dst_c < c: W.
  - Else dst_r > r: S. dst_r < r: N.
  - Else L (eject).
- Self-addressed flits eject at the source router.
- Each of the 5 outputs has a round-robin arbiter over the requesting inputs, with priority order L, N, S, E, W.
  - After a grant, the pointer moves to the input after the winner.
  - An input requests only one output, so no input gets two grants.
- A grant transfers the flit only when the target can accept it:
  - Neighbour input FIFO: FIFO not full.
  - L output: out_valid=0 or out_ready=1.
  - On transfer, the head is popped the same edge.
- The L output is a register. out_valid/out_data hold stable until out_ready=1.
- in_ready[n] = local FIFO of router n not full. This is purely registered state; there is no combinational path from out_ready to in_ready.
- Ordering: flits from the same source to the same destination are delivered in injection order. XY routing is deadlock-free.
- Flits are never dropped or duplicated. Every dst value is valid.

## Timing
- A transfer occurs on an edge where valid and ready are both 1.
- Uncontested latency: a flit accepted at edge k is visible on out_valid after edge k+1+H, where H is the Manhattan distance.
  - Self-addressed: 1 cycle. Corner to corner (H=6): 7 cycles.
- Throughput: 1 flit/cycle per link under continuous out_ready.
- Reset (rst_n low, asynchronous), applied immediately:
  - All FIFOs empty.
  - out_valid=0, out_data=0, in_ready=all 1.
  - Arbiter pointers at L.
  - stat_delivered=0.
- Reset mid-operation discards all in-flight flits.
- Simultaneous push and pop on a full FIFO is not allowed, because ready is computed from the pre-edge state. A FIFO holding 1 entry accepts a push and a pop on the same edge.

## Configuration
- NOC_STATS_EN defined:
  - stat_delivered port exists.
  - It increments by popcount(out_valid & out_ready) each edge and saturates at 16'hFFFF.
- NOC_STATS_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package noc_mesh_pkg holds:
  - Constants: MESH_DIM=4, DATA_W, FLIT_W.
  - Port enum L/N/S/E/W.
  - Packed flit_t struct {dst_r, dst_c, src_r, src_c, payload}.
  - Function route(flit_t, r, c) returning the port.
- One sub-module, noc_router:
  - Parameters R and C.
  - 5 input FIFOs, route compute, 5 round-robin arbiters, crossbar, L output register.
- noc_mesh instantiates 16 routers via generate and wires the neighbour links.

## Test plan
- Reset, then node (0,0) sends dst (0,0), payload 0x5A: out_valid[0] rises 1 cycle after acceptance with an identical flit. in_ready=16'hFFFF at reset.
- (0,0) sends to (3,3), payload 0xC3, out_ready all 1: arrives at out[15] after 7 cycles. No other out_valid pulses.
- All 16 nodes send simultaneously to (1,2), payloads = n: node 6 receives all 16 exactly once. Per-source order holds across a second round of payloads n+16.
- out_ready[5]=0 while (0,0) streams 10 flits to (1,1):
  - in_ready[0] eventually drops to 0.
  - out_data[5] stays stable while stalled.
  - Raising out_ready delivers all 10 in order.
- Random traffic, 10000 flits, random out_ready: scoreboard shows no loss, no duplication, per-pair order preserved. With NOC_STATS_EN, stat_delivered = 10000.
- rst_n pulsed low mid-traffic: out_valid=0 immediately, and new traffic after reset is delivered correctly.
